// File: rtl/ps_kernel_pkg.sv
// Shared definitions for the 3x3 convolution kernel: mode encodings,
// built-in coefficient tables and width-derivation helpers.
package ps_kernel_pkg;

  typedef enum logic [2:0] {
    MODE_GAUSS   = 3'd0,
    MODE_BOX     = 3'd1,
    MODE_SHARPEN = 3'd2,
    MODE_SOBELX  = 3'd3,
    MODE_SOBELY  = 3'd4,
    MODE_USER    = 3'd5,
    MODE_IDENT   = 3'd6,
    MODE_IDENT2  = 3'd7
  } kmode_e;

  localparam int NTAPS  = 9;
  localparam int SIDE_W = 5;

  localparam int GAUSS_TBL   [NTAPS] = '{ 1,  2,  1,  2,  4,  2,  1,  2,  1};
  localparam int BOX_TBL     [NTAPS] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1};
  localparam int SHARPEN_TBL [NTAPS] = '{ 0, -1,  0, -1,  5, -1,  0, -1,  0};
  localparam int SOBELX_TBL  [NTAPS] = '{-1,  0,  1, -2,  0,  2, -1,  0,  1};
  localparam int SOBELY_TBL  [NTAPS] = '{-1, -2, -1,  0,  0,  0,  1,  2,  1};
  localparam int IDENT_TBL   [NTAPS] = '{ 0,  0,  0,  0,  1,  0,  0,  0,  0};

  function automatic int prodWidth(input int dataW, input int coefW);
    return dataW + coefW + 1;
  endfunction

  // Nine products need 4 guard bits so the sum can never wrap.
  function automatic int accWidth(input int dataW, input int coefW);
    return prodWidth(dataW, coefW) + 4;
  endfunction

  // The user bank resets to gaussian, so MODE_USER maps to that table here.
  function automatic int builtinCoef(input kmode_e mode, input logic [3:0] tap);
    case (mode)
      MODE_GAUSS, MODE_USER: return GAUSS_TBL[tap];
      MODE_BOX:              return BOX_TBL[tap];
      MODE_SHARPEN:          return SHARPEN_TBL[tap];
      MODE_SOBELX:           return SOBELX_TBL[tap];
      MODE_SOBELY:           return SOBELY_TBL[tap];
      default:               return IDENT_TBL[tap];
    endcase
  endfunction

endpackage

// File: rtl/ps_addtree9.sv
// Registered nine-input signed adder tree with valid and sideband that hold
// whenever the pipeline enable is low.
module ps_addtree9
  import ps_kernel_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 21,
  parameter int SB_W  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [NTAPS*IN_W-1:0]   i_terms,
  input  logic [SB_W-1:0]         i_side,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_sum,
  output logic [SB_W-1:0]         o_side
);

  logic signed [OUT_W-1:0] term_d [NTAPS];
  logic signed [OUT_W-1:0] pair_d [4];
  logic signed [OUT_W-1:0] quad_d [2];
  logic signed [OUT_W-1:0] sum_d;

  logic                    valid_q;
  logic signed [OUT_W-1:0] sum_q;
  logic [SB_W-1:0]         side_q;

  always_comb begin
    for (int n = 0; n < NTAPS; n++) begin
      term_d[n] = OUT_W'($signed(i_terms[n*IN_W +: IN_W]));
    end
    for (int m = 0; m < 4; m++) begin
      pair_d[m] = term_d[2*m] + term_d[2*m+1];
    end
    quad_d[0] = pair_d[0] + pair_d[1];
    quad_d[1] = pair_d[2] + pair_d[3];
    sum_d     = quad_d[0] + quad_d[1] + term_d[8];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      side_q  <= '0;
    end else if (i_en) begin
      valid_q <= i_valid;
      sum_q   <= sum_d;
      side_q  <= i_side;
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_side  = side_q;

endmodule

// File: rtl/ps_kernel3x3.sv
// 3x3 convolution with selectable kernels: capture, multiply, sum, then
// abs/shift/saturate, all under one stall-able enable.
module ps_kernel3x3
  import ps_kernel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [3*DATA_W-1:0] i_r0_data,
  input  logic [3*DATA_W-1:0] i_r1_data,
  input  logic [3*DATA_W-1:0] i_r2_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_mode,
  input  logic [3:0]          i_shift,
  input  logic                i_abs,
  input  logic                i_coef_wr,
  input  logic [COEF_W-1:0]   i_coef_data,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  input  logic                i_ready
);

  localparam int PROD_W = prodWidth(DATA_W, COEF_W);
  localparam int ACC_W  = accWidth(DATA_W, COEF_W);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  logic en;

  logic [DATA_W-1:0]        pix_d   [NTAPS];
  logic signed [COEF_W-1:0] coef_d  [NTAPS];
  logic signed [COEF_W-1:0] bank_q  [NTAPS];
  logic [3:0]               wrIdx_q;

  logic                     valid1_q;
  logic [DATA_W-1:0]        pix1_q  [NTAPS];
  logic signed [COEF_W-1:0] coef1_q [NTAPS];
  logic [SIDE_W-1:0]        side1_q;

  logic [NTAPS*PROD_W-1:0]  prod_d;
  logic [NTAPS*PROD_W-1:0]  prod2_q;
  logic                     valid2_q;
  logic [SIDE_W-1:0]        side2_q;

  logic                     valid3;
  logic signed [ACC_W-1:0]  sum3;
  logic [SIDE_W-1:0]        side3;

  logic signed [ACC_W-1:0]  mag_d;
  logic signed [ACC_W-1:0]  shifted_d;
  logic [DATA_W-1:0]        data_d;
  logic                     oValid_q;
  logic [DATA_W-1:0]        oData_q;

  function automatic logic signed [PROD_W-1:0] mulPixCoef(
    input logic [DATA_W-1:0]        p,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PROD_W-1:0] pe;
    logic signed [PROD_W-1:0] ce;
    pe = $signed({{(PROD_W-DATA_W){1'b0}}, p});
    ce = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    return pe * ce;
  endfunction

  // An empty output register never blocks, so bubbles collapse for free.
  assign en      = i_ready | ~oValid_q;
  assign o_ready = en;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pix_d[k]   = i_r0_data[k*DATA_W +: DATA_W];
      pix_d[3+k] = i_r1_data[k*DATA_W +: DATA_W];
      pix_d[6+k] = i_r2_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int n = 0; n < NTAPS; n++) begin
      if (kmode_e'(i_mode) == MODE_USER) coef_d[n] = bank_q[n];
      else coef_d[n] = COEF_W'(builtinCoef(kmode_e'(i_mode), 4'(n)));
    end
  end

  // Coefficient writes ignore the stall so software never waits on video.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wrIdx_q <= '0;
      for (int n = 0; n < NTAPS; n++) begin
        bank_q[n] <= COEF_W'(builtinCoef(MODE_GAUSS, 4'(n)));
      end
    end else if (i_coef_wr) begin
      bank_q[wrIdx_q] <= i_coef_data;
      wrIdx_q         <= (wrIdx_q == 4'd8) ? 4'd0 : wrIdx_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid1_q <= 1'b0;
      pix1_q   <= '{default: '0};
      coef1_q  <= '{default: '0};
      side1_q  <= '0;
    end else if (en) begin
      valid1_q <= i_valid;
      pix1_q   <= pix_d;
      coef1_q  <= coef_d;
      side1_q  <= {i_abs, i_shift};
    end
  end

  always_comb begin
    prod_d = '0;
    for (int n = 0; n < NTAPS; n++) begin
      prod_d[n*PROD_W +: PROD_W] = mulPixCoef(pix1_q[n], coef1_q[n]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid2_q <= 1'b0;
      prod2_q  <= '0;
      side2_q  <= '0;
    end else if (en) begin
      valid2_q <= valid1_q;
      prod2_q  <= prod_d;
      side2_q  <= side1_q;
    end
  end

  ps_addtree9 #(
    .IN_W  (PROD_W),
    .OUT_W (ACC_W),
    .SB_W  (SIDE_W)
  ) u_addtree (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_en    (en),
    .i_valid (valid2_q),
    .i_terms (prod2_q),
    .i_side  (side2_q),
    .o_valid (valid3),
    .o_sum   (sum3),
    .o_side  (side3)
  );

  always_comb begin
    mag_d     = (side3[4] && sum3[ACC_W-1]) ? -sum3 : sum3;
    shifted_d = mag_d >>> side3[3:0];
    if (shifted_d[ACC_W-1])      data_d = '0;
    else if (shifted_d > PIX_MAX) data_d = '1;
    else                          data_d = shifted_d[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      oValid_q <= 1'b0;
      oData_q  <= '0;
    end else if (en) begin
      oValid_q <= valid3;
      if (valid3) oData_q <= data_d;
    end
  end

  assign o_valid = oValid_q;
  assign o_data  = oData_q;

endmodule

// File: tb/tb_ps_kernel3x3.sv
// Directed bench for ps_kernel3x3: hand-computed windows checked with
// immediate assertions, including stalls, user coefficients and reset.
module tb_ps_kernel3x3;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;

  logic                i_clk;
  logic                i_rstn;
  logic [3*DATA_W-1:0] i_r0_data;
  logic [3*DATA_W-1:0] i_r1_data;
  logic [3*DATA_W-1:0] i_r2_data;
  logic                i_valid;
  logic                o_ready;
  logic [2:0]          i_mode;
  logic [3:0]          i_shift;
  logic                i_abs;
  logic                i_coef_wr;
  logic [COEF_W-1:0]   i_coef_data;
  logic [DATA_W-1:0]   o_data;
  logic                o_valid;
  logic                i_ready;

  int nVectors;
  int nMiscompares;

  ps_kernel3x3 #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_r0_data   (i_r0_data),
    .i_r1_data   (i_r1_data),
    .i_r2_data   (i_r2_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mode      (i_mode),
    .i_shift     (i_shift),
    .i_abs       (i_abs),
    .i_coef_wr   (i_coef_wr),
    .i_coef_data (i_coef_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] row3(input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [7:0] p2);
    return {p2, p1, p0};
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic applyStimulus(input logic [23:0] r0, input logic [23:0] r1,
                               input logic [23:0] r2, input logic [2:0] mode,
                               input logic [3:0] shift, input logic abs,
                               input logic valid);
    i_r0_data = r0;
    i_r1_data = r1;
    i_r2_data = r2;
    i_mode    = mode;
    i_shift   = shift;
    i_abs     = abs;
    i_valid   = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated window on an empty pipeline, checked for exact 4-cycle latency.
  task automatic runOne(input string tag, input logic [23:0] r0, input logic [23:0] r1,
                        input logic [23:0] r2, input logic [2:0] mode,
                        input logic [3:0] shift, input logic abs,
                        input logic [7:0] expData);
    applyStimulus(r0, r1, r2, mode, shift, abs, 1'b1);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    checkOutput({tag, "_early"}, 32'(o_valid), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(o_data), 32'(expData));
    tick();
  endtask

  initial begin
    logic [23:0] w0, w1, w2;
    int inIdx, outIdx, cyc;

    nVectors     = 0;
    nMiscompares = 0;
    w0 = row3(10, 20, 30);
    w1 = row3(40, 50, 60);
    w2 = row3(70, 80, 90);

    i_rstn      = 1'b0;
    i_ready     = 1'b1;
    i_coef_wr   = 1'b0;
    i_coef_data = '0;
    applyStimulus('0, '0, '0, 3'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("rst_ovalid", 32'(o_valid), 32'd0);
    checkOutput("rst_odata", 32'(o_data), 32'd0);
    i_rstn  = 1'b1;
    i_ready = 1'b0;
    #1;
    checkOutput("rel_oready", 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    tick();

    runOne("gauss100", row3(100, 100, 100), row3(100, 100, 100), row3(100, 100, 100),
           3'd0, 4'd4, 1'b0, 8'd100);
    runOne("sobx_sat_hi", row3(0, 77, 255), row3(0, 77, 255), row3(0, 77, 255),
           3'd3, 4'd0, 1'b1, 8'd255);
    runOne("sobx_sat_lo", row3(255, 77, 0), row3(255, 77, 0), row3(255, 77, 0),
           3'd3, 4'd0, 1'b0, 8'd0);
    runOne("sobx_shift", row3(0, 9, 10), row3(0, 9, 10), row3(0, 9, 10),
           3'd3, 4'd2, 1'b0, 8'd10);
    runOne("sobx_neg_abs", row3(10, 9, 0), row3(10, 9, 0), row3(10, 9, 0),
           3'd3, 4'd2, 1'b1, 8'd10);
    runOne("box", row3(8, 8, 8), row3(8, 8, 8), row3(8, 8, 8),
           3'd1, 4'd3, 1'b0, 8'd9);
    runOne("box_sat", row3(255, 255, 255), row3(255, 255, 255), row3(255, 255, 255),
           3'd1, 4'd3, 1'b0, 8'd255);
    runOne("sharpen", row3(50, 50, 50), row3(50, 80, 50), row3(50, 50, 50),
           3'd2, 4'd0, 1'b0, 8'd200);
    runOne("soby", row3(0, 0, 0), row3(99, 99, 99), row3(30, 30, 30),
           3'd4, 4'd0, 1'b0, 8'd120);
    runOne("ident7", w0, w1, w2, 3'd7, 4'd0, 1'b0, 8'd50);

    $display("[TB] back-to-back mode switching");
    for (int c = 0; c < 8; c++) begin
      if (c >= 4) begin
        checkOutput($sformatf("switch%0d_valid", c - 4), 32'(o_valid), 32'd1);
        checkOutput($sformatf("switch%0d_data", c - 4), 32'(o_data),
                    ((c - 4) % 2 == 0) ? 32'd100 : 32'd50);
      end
      if (c < 4)
        applyStimulus(w0, w1, w2, (c % 2 == 0) ? 3'd0 : ((c == 1) ? 3'd6 : 3'd7),
                      (c % 2 == 0) ? 4'd3 : 4'd0, 1'b0, 1'b1);
      else
        i_valid = 1'b0;
      tick();
    end

    $display("[TB] backpressure stream");
    inIdx  = 0;
    outIdx = 0;
    cyc    = 0;
    while (outIdx < 10 && cyc < 80) begin
      i_ready = !(cyc >= 6 && cyc < 11);
      if (inIdx < 10)
        applyStimulus(row3(0, 0, 0), row3(0, 8'(10 + inIdx), 0), row3(0, 0, 0),
                      3'd6, 4'd0, 1'b0, 1'b1);
      else
        i_valid = 1'b0;
      #1;
      if (o_valid && !i_ready)
        checkOutput($sformatf("bp_hold%0d", outIdx), 32'(o_data), 32'(10 + outIdx));
      if (o_valid && i_ready) begin
        checkOutput($sformatf("bp_out%0d", outIdx), 32'(o_data), 32'(10 + outIdx));
        outIdx++;
      end
      if (i_valid && o_ready) inIdx++;
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checkOutput("bp_out_count", 32'(outIdx), 32'd10);
    checkOutput("bp_in_count", 32'(inIdx), 32'd10);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("bp_nodup%0d", c), 32'(o_valid), 32'd0);
      tick();
    end

    $display("[TB] user coefficient bank");
    i_coef_wr = 1'b1;
    for (int n = 0; n < 9; n++) begin
      i_coef_data = (n == 4) ? 8'd2 : 8'd0;
      tick();
    end
    i_coef_wr = 1'b0;
    runOne("user_centre", row3(200, 200, 200), row3(200, 60, 200), row3(200, 200, 200),
           3'd5, 4'd1, 1'b0, 8'd60);
    i_coef_wr   = 1'b1;
    i_coef_data = 8'd1;
    tick();
    i_coef_wr = 1'b0;

    applyStimulus(row3(40, 10, 200), row3(200, 60, 200), row3(200, 200, 200),
                  3'd5, 4'd1, 1'b0, 1'b1);
    tick();
    i_valid     = 1'b0;
    i_coef_wr   = 1'b1;
    i_coef_data = 8'd3;
    tick();
    i_coef_wr = 1'b0;
    tick();
    checkOutput("user_inflight_early", 32'(o_valid), 32'd0);
    tick();
    checkOutput("user_inflight_valid", 32'(o_valid), 32'd1);
    checkOutput("user_inflight_data", 32'(o_data), 32'd80);
    tick();
    runOne("user_after_wr", row3(40, 10, 200), row3(200, 60, 200), row3(200, 200, 200),
           3'd5, 4'd1, 1'b0, 8'd95);

    $display("[TB] reset with windows in flight");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(row3(100, 100, 100), row3(100, 100, 100), row3(100, 100, 100),
                    3'd0, 4'd4, 1'b0, 1'b1);
      tick();
    end
    i_valid = 1'b0;
    i_rstn  = 1'b0;
    tick();
    tick();
    checkOutput("midrst_odata", 32'(o_data), 32'd0);
    i_rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("midrst_quiet%0d", c), 32'(o_valid), 32'd0);
      tick();
    end
    runOne("midrst_user_gauss", w0, w1, w2, 3'd5, 4'd3, 1'b0, 8'd100);
    i_coef_wr   = 1'b1;
    i_coef_data = 8'd0;
    tick();
    i_coef_wr = 1'b0;
    runOne("midrst_wridx0", w0, w1, w2, 3'd5, 4'd3, 1'b0, 8'd98);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
